param_muldiv_unit: RTL and testbench

Parametrised multiply/divide unit for the pipelined CPU. It handles signed and unsigned multiply and divide on WIDTH-bit operands using a valid/ready handshake. The multiplier has configurable fixed latency. The divider is a bit-serial restoring divider with defined divide-by-zero and overflow results. A synchronous abort cancels in-flight work on exception or interrupt.

---
 rtl/param_muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_param_muldiv_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_muldiv_unit.sv
// param_muldiv_unit: signed/unsigned multiply (fixed latency) and bit-serial restoring divide.
// Define MULDIV_DIV_EARLY_EN to let trivial divides skip the bit-serial loop.
module param_muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_src0,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [1:0]       in_op,
  input  logic             in_sign,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_res0,
  output logic [WIDTH-1:0] out_res1,
  output logic             busy
);
  localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;

  typedef enum logic [2:0] {IDLE, MUL_BUSY, DIV_BUSY, DIV_FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // opa holds the multiplicand, or the dividend magnitude that shifts out as quotient bits shift in
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] src0_q, src0_d;
  logic             sign_q, sign_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] res0_q, res0_d;
  logic [WIDTH-1:0] res1_q, res1_d;

  logic                 a_neg, b_neg, early;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   mul_a, mul_b, prod;
  logic [WIDTH+1:0]     trial;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    a_neg = in_sign & in_src0[WIDTH-1];
    b_neg = in_sign & in_src1[WIDTH-1];
    a_mag = magnitude(in_src0, a_neg);
    b_mag = magnitude(in_src1, b_neg);
`ifdef MULDIV_DIV_EARLY_EN
    early = (in_src1 == '0) || (a_mag == '0) || (a_mag < b_mag);
`else
    early = 1'b0;
`endif

    mul_a = {{WIDTH{sign_q & opa_q[WIDTH-1]}}, opa_q};
    mul_b = {{WIDTH{sign_q & opb_q[WIDTH-1]}}, opb_q};
    prod  = mul_a * mul_b;

    // Trial subtraction of the divisor from the shifted partial remainder; MSB set means restore.
    trial = {rem_q, opa_q[WIDTH-1]} - {2'b00, opb_q};

    quot_fix = div0_q ? '1 : magnitude(opa_q, qneg_q);
    rem_fix  = div0_q ? src0_q : magnitude(rem_q[WIDTH-1:0], rneg_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    src0_d  = src0_q;
    sign_d  = sign_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    res0_d  = res0_q;
    res1_d  = res1_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_op == OP_MUL) begin
            state_d = MUL_BUSY;
            cnt_d   = CNT_W'(MUL_LATENCY - 1);
            opa_d   = in_src0;
            opb_d   = in_src1;
            sign_d  = in_sign;
          end else if (in_valid && in_op == OP_DIV) begin
            state_d = DIV_BUSY;
            cnt_d   = CNT_W'(WIDTH);
            opa_d   = a_mag;
            opb_d   = b_mag;
            rem_d   = '0;
            src0_d  = in_src0;
            sign_d  = in_sign;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            div0_d  = (in_src1 == '0);
            if (early) begin
              state_d = DIV_FIX;
              opa_d   = '0;
              rem_d   = {1'b0, a_mag};
            end
          end
        end
        MUL_BUSY: begin
          if (cnt_q == '0) begin
            state_d = DONE;
            res0_d  = prod[WIDTH-1:0];
            res1_d  = prod[2*WIDTH-1:WIDTH];
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DIV_BUSY: begin
          opa_d = {opa_q[WIDTH-2:0], ~trial[WIDTH+1]};
          rem_d = trial[WIDTH+1] ? {rem_q[WIDTH-1:0], opa_q[WIDTH-1]} : trial[WIDTH:0];
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DIV_FIX;
          end
        end
        DIV_FIX: begin
          state_d = DONE;
          res0_d  = quot_fix;
          res1_d  = rem_fix;
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      src0_q  <= '0;
      sign_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      res0_q  <= '0;
      res1_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      src0_q  <= src0_d;
      sign_q  <= sign_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_res0  = res0_q;
  assign out_res1  = res1_q;

endmodule

// File: tb/tb_param_muldiv_unit.sv
// tb_param_muldiv_unit: directed vectors for param_muldiv_unit, checked every cycle against
// a behavioural model of handshake timing and arithmetic results.
`timescale 1ns/1ps
module tb_param_muldiv_unit;
  localparam int W       = 32;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = W + 1;
`ifdef MULDIV_DIV_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int DL_EARLY = EARLY ? 2 : DIV_LAT;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic [W-1:0] in_src0   = '0;
  logic [W-1:0] in_src1   = '0;
  logic [1:0]   in_op     = 2'b00;
  logic         in_sign   = 1'b0;
  logic         in_valid  = 1'b0;
  logic         abort     = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] out_res0, out_res1;

  int       checks   = 0;
  int       errors   = 0;
  int       edge_n   = 0;
  int       done_at  = 0;
  int       acc_edge = 0;
  bit       pending  = 1'b0;
  bit       cmp_en   = 1'b0;
  logic [W-1:0] exp0 = '0;
  logic [W-1:0] exp1 = '0;

  param_muldiv_unit #(.WIDTH(W), .MUL_LATENCY(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .in_src0(in_src0), .in_src1(in_src1), .in_op(in_op),
    .in_sign(in_sign), .in_valid(in_valid), .in_ready(in_ready), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .out_res0(out_res0),
    .out_res1(out_res1), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Returns {res1, res0} from plain integer arithmetic.
  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic sgn,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              qs, rs;
    int unsigned     qu, ru;
    if (op == 2'b01) begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      ua = {32'b0, a};
      ub = {32'b0, b};
      return ua * ub;
    end
    if (b == '0) return {a, {W{1'b1}}};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      qs = $signed(a) / $signed(b);
      rs = $signed(a) % $signed(b);
      return {32'(rs), 32'(qs)};
    end
    qu = a / b;
    ru = a % b;
    return {ru, qu};
  endfunction

  function automatic int div_lat(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ma, mb;
    ma = (sgn && a[W-1]) ? -a : a;
    mb = (sgn && b[W-1]) ? -b : b;
    if (EARLY && (b == '0 || ma == '0 || ma < mb)) return 2;
    return DIV_LAT;
  endfunction

  always @(posedge clk) begin
    logic [2*W-1:0] r;
    bit ov;
    ov = pending && (edge_n >= done_at);
    edge_n++;
    if (reset || abort) begin
      pending = 1'b0;
    end else if (pending) begin
      if (ov && out_ready) pending = 1'b0;
    end else if (in_valid && (in_op == 2'b01 || in_op == 2'b10)) begin
      r       = model(in_op, in_sign, in_src0, in_src1);
      exp0    = r[W-1:0];
      exp1    = r[2*W-1:W];
      done_at = edge_n + ((in_op == 2'b01) ? MUL_LAT : div_lat(in_sign, in_src0, in_src1));
      pending = 1'b1;
    end
  end

  always @(negedge clk) begin
    bit pend, ov;
    if (cmp_en) begin
      pend = pending && !reset;
      ov   = pend && (edge_n >= done_at);
      chk("out_valid", 32'(out_valid), 32'(ov));
      chk("in_ready", 32'(in_ready), 32'(!pend));
      chk("busy", 32'(busy), 32'(pend));
      if (ov) begin
        chk("res0", out_res0, exp0);
        chk("res1", out_res1, exp1);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_op    = op;
    in_sign  = sgn;
    in_src0  = a;
    in_src1  = b;
    in_valid = 1'b1;
    acc_edge = edge_n + 1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_op    = 2'b00;
    in_sign  = ~sgn;
    in_src0  = $urandom;
    in_src1  = $urandom;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout: out_valid never rose within 200 cycles");
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                        input logic [W-1:0] e0, input logic [W-1:0] e1);
    bit ok;
    issue(op, sgn, a, b);
    wait_done(ok);
    if (ok) begin
      chk({nm, "_lat"}, 32'(edge_n - acc_edge), 32'(lat));
      chk({nm, "_r0"}, out_res0, e0);
      chk({nm, "_r1"}, out_res1, e1);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    logic [2*W-1:0] m;
    bit ok, seen;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res0", out_res0, 32'd0);
    chk("rst_res1", out_res1, 32'd0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    m = model(2'b01, 1'b1, 32'hFFFF_FFFE, 32'd3);
    chk("model_smul_hi", m[63:32], 32'hFFFF_FFFF);
    chk("model_smul_lo", m[31:0], 32'hFFFF_FFFA);
    m = model(2'b01, 1'b0, 32'hFFFF_FFFE, 32'd3);
    chk("model_umul_hi", m[63:32], 32'h0000_0002);
    m = model(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2);
    chk("model_sdiv_q", m[31:0], 32'hFFFF_FFFD);
    chk("model_sdiv_r", m[63:32], 32'hFFFF_FFFF);
    m = model(2'b10, 1'b0, 32'd5, 32'd0);
    chk("model_div0_r", m[63:32], 32'd5);

    run_op("smul",    2'b01, 1'b1, 32'hFFFF_FFFE, 32'd3,         MUL_LAT,  32'hFFFF_FFFA, 32'hFFFF_FFFF);
    run_op("umul",    2'b01, 1'b0, 32'hFFFF_FFFE, 32'd3,         MUL_LAT,  32'hFFFF_FFFA, 32'h0000_0002);
    run_op("smul_nn", 2'b01, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFF9, MUL_LAT,  32'd35,        32'd0);
    run_op("sdiv",    2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2,         DIV_LAT,  32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("sdiv_pn", 2'b10, 1'b1, 32'd7,         32'hFFFF_FFFE, DIV_LAT,  32'hFFFF_FFFD, 32'd1);
    run_op("sdiv_nn", 2'b10, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, DIV_LAT,  32'd3,         32'hFFFF_FFFF);
    run_op("udiv0",   2'b10, 1'b0, 32'd5,         32'd0,         DL_EARLY, 32'hFFFF_FFFF, 32'd5);
    run_op("sdiv0",   2'b10, 1'b1, 32'hFFFF_FFF8, 32'd0,         DL_EARLY, 32'hFFFF_FFFF, 32'hFFFF_FFF8);
    run_op("sdivovf", 2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,  32'h8000_0000, 32'd0);
    run_op("udivsm",  2'b10, 1'b0, 32'd3,         32'd7,         DL_EARLY, 32'd0,         32'd3);
    run_op("sdivz",   2'b10, 1'b1, 32'd0,         32'd5,         DL_EARLY, 32'd0,         32'd0);
    run_op("udiv",    2'b10, 1'b0, 32'd100,       32'd7,         DIV_LAT,  32'd14,        32'd2);
    run_op("udivbig", 2'b10, 1'b0, 32'hFFFF_FFFF, 32'd10,        DIV_LAT,  32'h1999_9999, 32'd5);

    // Abort part-way through a divide
    issue(2'b10, 1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    @(posedge clk); #2;
    run_op("mul76", 2'b01, 1'b0, 32'd7, 32'd6, MUL_LAT, 32'd42, 32'd0);

    // Abort together with a request in IDLE
    in_op    = 2'b01;
    in_src0  = 32'd9;
    in_src1  = 32'd9;
    in_valid = 1'b1;
    abort    = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    abort    = 1'b0;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_rdy", 32'(in_ready), 32'd1);

    // Reserved opcode
    in_op    = 2'b11;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    in_op    = 2'b00;
    chk("rsv_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #2;

    // Result held while the consumer stalls
    out_ready = 1'b0;
    issue(2'b01, 1'b1, 32'hFFFF_FFFD, 32'd4);
    wait_done(ok);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_r0", out_res0, 32'hFFFF_FFF4);
      chk("hold_r1", out_res1, 32'hFFFF_FFFF);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("hold_release", 32'(out_valid), 32'd0);

    // Abort while DONE drops the result
    out_ready = 1'b0;
    issue(2'b01, 1'b0, 32'd2, 32'd3);
    wait_done(ok);
    abort = 1'b1;
    @(posedge clk); #2;
    abort     = 1'b0;
    out_ready = 1'b1;
    chk("abort_done_valid", 32'(out_valid), 32'd0);
    chk("abort_done_rdy", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of a divide
    issue(2'b10, 1'b0, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_in_ready", 32'(in_ready), 32'd1);
    chk("areset_valid", 32'(out_valid), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_res0", out_res0, 32'd0);
    chk("areset_res1", out_res1, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    run_op("post_rst", 2'b10, 1'b0, 32'd100, 32'd7, DIV_LAT, 32'd14, 32'd2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
